// File: rtl/seg_anim_sequencer.sv
// Pattern/step sequencer for the 7-segment animation display: programmable
// step prescaler, auto advance with hold, and a debounced manual step button.
module seg_anim_sequencer #(
  parameter logic [23:0] MAX_COUNT       = 24'd10_000_000,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] speed,
  input  logic       hold,
  input  logic       step_btn,
  output logic [2:0] pattern,
  output logic [3:0] step,
  output logic       tick,
  output logic [7:0] prescale_lsb
);

  typedef enum logic [2:0] {
    PAT_DIGITS = 3'd0,
    PAT_ANIM_A = 3'd1,
    PAT_ANIM_B = 3'd2,
    PAT_ANIM_C = 3'd3,
    PAT_ANIM_D = 3'd4,
    PAT_ANIM_E = 3'd5
  } pattern_e;

  logic [23:0] pc_q, pc_d;
  logic        sync1_q, sync2_q;
  logic        stable_q, stable_d;
  logic [15:0] dcnt_q, dcnt_d;
  pattern_e    pattern_q, pattern_d;
  logic [3:0]  step_q, step_d;
  logic        tick_q, tick_d;

  logic [23:0] compare;
  logic        tick_ev;
  logic        manual;
  logic [3:0]  step_max;
  pattern_e    next_pat;
  logic        pat_ok;

  always_comb begin
    step_max = 4'd9;
    next_pat = PAT_DIGITS;
    pat_ok   = 1'b1;
    case (pattern_q)
      PAT_DIGITS: begin step_max = 4'd9; next_pat = PAT_ANIM_A; end
      PAT_ANIM_A: begin step_max = 4'd6; next_pat = PAT_ANIM_B; end
      PAT_ANIM_B: begin step_max = 4'd6; next_pat = PAT_ANIM_C; end
      PAT_ANIM_C: begin step_max = 4'd6; next_pat = PAT_ANIM_D; end
      PAT_ANIM_D: begin step_max = 4'd5; next_pat = PAT_ANIM_E; end
      PAT_ANIM_E: begin step_max = 4'd5; next_pat = PAT_DIGITS; end
      default:    begin pat_ok   = 1'b0; end
    endcase
  end

  always_comb begin
    compare = (speed == 8'd0) ? MAX_COUNT : {6'b0, speed, 10'b0};
    // >= rather than == so lowering speed never waits for a 2^24 wrap
    tick_ev = (pc_q >= compare);

    stable_d = stable_q;
    dcnt_d   = '0;
    if (sync2_q != stable_q) begin
      if (dcnt_q == DEBOUNCE_CYCLES - 16'd1) begin
        stable_d = sync2_q;
      end else begin
        dcnt_d = dcnt_q + 16'd1;
      end
    end
    manual = stable_d & ~stable_q;

    pc_d = (manual || tick_ev) ? '0 : pc_q + 24'd1;

    pattern_d = pattern_q;
    step_d    = step_q;
    tick_d    = 1'b0;
    if (!pat_ok) begin
      pattern_d = PAT_DIGITS;
      step_d    = '0;
    end else if (manual) begin
      // manual advance outranks a coincident tick: one increment, no tick pulse
      pattern_d = next_pat;
      step_d    = '0;
    end else if (tick_ev) begin
      tick_d = 1'b1;
      if (step_q < step_max) begin
        step_d = step_q + 4'd1;
      end else begin
        step_d = '0;
        if (!hold) begin
          pattern_d = next_pat;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= '0;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      stable_q  <= 1'b0;
      dcnt_q    <= '0;
      pattern_q <= PAT_DIGITS;
      step_q    <= '0;
      tick_q    <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      sync1_q   <= step_btn;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      dcnt_q    <= dcnt_d;
      pattern_q <= pattern_d;
      step_q    <= step_d;
      tick_q    <= tick_d;
    end
  end

  assign pattern      = pattern_q;
  assign step         = step_q;
  assign tick         = tick_q;
  assign prescale_lsb = pc_q[7:0];

endmodule
